ldpc_iter_ctrl: RTL and testbench
=================================

LDPC_ITER_CTRL -- requirements
Module: ldpc_iter_ctrl

Interface
REQ-001 Parameter MAX_ITER_W, default 5, width of the iteration-limit and iteration-count fields.
REQ-002 Parameter VN_LAT, default 1, number of cycles in the variable-node phase (VN array output register depth).
REQ-003 Parameter CN_LAT, default 2, number of cycles in the check-node phase.
REQ-004 i_clk  in  1  clock; all logic is rising-edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_start  in  1  frame request; channel LLRs are valid at the same edge.
REQ-007 i_max_iter  in  MAX_ITER_W  iteration limit, sampled only when i_start is accepted.
REQ-008 i_syn_ok  in  1  all parity checks satisfied; meaningful only in the CHECK state.
REQ-009 i_out_ready  in  1  downstream accepts the decoded frame.
REQ-010 o_busy  out  1  high in every state except IDLE.
REQ-011 o_llr_load  out  1  one-cycle strobe that captures channel LLRs into the VN array.
REQ-012 o_c2v_clr  out  1  forces the c2v inputs of the VN array to zero; high during LOAD and during the first VN phase only.
REQ-013 o_vn_en  out  1  VN array update enable; high throughout each VN phase.
REQ-014 o_cn_en  out  1  CN array update enable; high throughout each CN phase.
REQ-015 o_valid  out  1  decoded hard decisions (VN app bits) are ready.
REQ-016 o_success  out  1  the frame terminated on a zero syndrome; valid while o_valid is high.
REQ-017 o_iter  out  MAX_ITER_W  number of completed iterations; valid while o_valid is high.

Function
REQ-018 The FSM shall have the states IDLE, LOAD, VN, CN, CHECK and DONE; all state-dependent outputs shall be registered Moore outputs.
REQ-019 In IDLE, a sampled i_start=1 shall move the FSM to LOAD on the next cycle and latch lim = max(i_max_iter, 1); i_start shall be ignored in every other state.
REQ-020 LOAD shall last exactly 1 cycle, shall assert o_llr_load and o_c2v_clr, shall clear iter to 0, and shall then go to VN.
REQ-021 VN shall last exactly VN_LAT cycles and CN exactly CN_LAT cycles, timed by a phase counter that reloads on every phase entry; the order shall be VN, then CN, then CHECK.
REQ-022 CHECK shall last 1 cycle and shall set iter to iter+1.
REQ-023 In CHECK, i_syn_ok=1 shall go to DONE with o_success=1.
REQ-024 In CHECK, if i_syn_ok=0 and iter+1 >= lim, the FSM shall go to DONE with o_success=0.
REQ-025 In CHECK, in all other cases, the FSM shall go back to VN with o_c2v_clr=0.
REQ-026 In DONE, o_valid shall be 1, and o_success and o_iter shall be held stable until i_out_ready=1 is sampled; the FSM shall then return to IDLE.
REQ-027 o_valid, o_success and o_iter shall not change while o_valid=1 and i_out_ready=0.
REQ-028 A frame takes 1 + iter*(VN_LAT+CN_LAT+1) cycles from the LOAD cycle through the final CHECK cycle.
REQ-029 The iteration counter shall saturate at all-ones and shall never wrap.
REQ-030 A back-to-back i_start arriving during DONE shall be dropped; the requester shall hold i_start until o_busy=0.

Reset
REQ-031 While i_rst_n=0 at a clock edge, the FSM shall enter IDLE and all outputs shall be 0 (o_busy, o_llr_load, o_c2v_clr, o_vn_en, o_cn_en, o_valid, o_success, o_iter); lim and the phase counter shall be cleared.
REQ-032 A reset asserted mid-frame in any state shall abort the frame with no o_valid pulse; decoding shall resume on the first i_start sampled after reset deasserts.

Structure
REQ-033 The state encoding (ldpc_ctrl_state_t) and the default widths and latencies shall be defined in the shared package ldpc_ctrl_pkg.
REQ-034 The phase timing shall be implemented as one sub-module, ldpc_phase_timer, a loadable down-counter with a terminal-count output; the FSM shall be implemented in ldpc_iter_ctrl.

Verification
REQ-035 Scenario: VN_LAT=1, CN_LAT=2, i_max_iter=5, i_start at c0, i_syn_ok=1 at the first CHECK -> LOAD at c1, VN at c2, CN at c3–c4, CHECK at c5, o_valid=1 at c6 with o_success=1 and o_iter=1.
REQ-036 Scenario: i_max_iter=3, i_syn_ok always 0 -> CHECK cycles at c5, c9 and c13; o_valid at c14 with o_success=0 and o_iter=3; o_c2v_clr high only in c1–c2.
REQ-037 Scenario: i_max_iter=0 -> behaves as limit 1; o_valid with o_iter=1.
REQ-038 Scenario: i_out_ready held 0 for 7 cycles during DONE, then set to 1 -> o_valid, o_success and o_iter stay stable throughout; IDLE and o_busy=0 on the cycle after acceptance; i_start pulses during busy have no effect.
REQ-039 Scenario: i_rst_n=0 for 1 cycle while in CN of iteration 2 -> all outputs are 0 next cycle and there is no o_valid; a fresh i_start afterwards completes normally.
REQ-040 Scenario: i_syn_ok=1 asserted outside CHECK (during VN and CN) -> ignored; termination occurs only on a CHECK-cycle sample.

Source files
------------

// File: rtl/ldpc_ctrl_pkg.sv
// ldpc_ctrl_pkg: shared state encoding and default parameters for the LDPC iteration controller
package ldpc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VN,
        S_CN,
        S_CHECK,
        S_DONE
    } ldpc_ctrl_state_t;

    localparam int DEF_MAX_ITER_W = 5;
    localparam int DEF_VN_LAT     = 1;
    localparam int DEF_CN_LAT     = 2;

    // Phase counter width: must hold the longer phase length minus one.
    function automatic int phase_w(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/ldpc_phase_timer.sv
// ldpc_phase_timer: loadable down-counter that stops at zero and flags terminal count
module ldpc_phase_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            cnt <= '0;
        else if (i_load)
            cnt <= i_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign o_tc = cnt == '0;

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: LDPC decoder iteration sequencer (load, VN/CN phases, syndrome check, handoff)
module ldpc_iter_ctrl
    import ldpc_ctrl_pkg::*;
#(
    parameter int MAX_ITER_W = DEF_MAX_ITER_W,
    parameter int VN_LAT     = DEF_VN_LAT,
    parameter int CN_LAT     = DEF_CN_LAT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [MAX_ITER_W-1:0] i_max_iter,
    input  logic                  i_syn_ok,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_llr_load,
    output logic                  o_c2v_clr,
    output logic                  o_vn_en,
    output logic                  o_cn_en,
    output logic                  o_valid,
    output logic                  o_success,
    output logic [MAX_ITER_W-1:0] o_iter
);

    localparam int PW = phase_w(VN_LAT, CN_LAT);

    ldpc_ctrl_state_t      state, nxt;
    logic [MAX_ITER_W-1:0] lim;
    logic                  tc, last, load;
    logic [PW-1:0]         load_val;

    // Widened compare so the all-ones iteration count cannot wrap past the limit.
    assign last = ({1'b0, o_iter} + (MAX_ITER_W+1)'(1)) >= {1'b0, lim};

    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE:  nxt = i_start ? S_LOAD : S_IDLE;
            S_LOAD:  nxt = S_VN;
            S_VN:    nxt = tc ? S_CN : S_VN;
            S_CN:    nxt = tc ? S_CHECK : S_CN;
            S_CHECK: nxt = (i_syn_ok || last) ? S_DONE : S_VN;
            S_DONE:  nxt = i_out_ready ? S_IDLE : S_DONE;
            default: nxt = S_IDLE;
        endcase
    end

    assign load     = (state == S_LOAD) || (state == S_VN && tc) || (state == S_CHECK && nxt == S_VN);
    assign load_val = state == S_VN ? PW'(CN_LAT - 1) : PW'(VN_LAT - 1);

    ldpc_phase_timer #(.W(PW)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (load),
        .i_val   (load_val),
        .o_tc    (tc)
    );

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            lim        <= '0;
            o_busy     <= 1'b0;
            o_llr_load <= 1'b0;
            o_c2v_clr  <= 1'b0;
            o_vn_en    <= 1'b0;
            o_cn_en    <= 1'b0;
            o_valid    <= 1'b0;
            o_success  <= 1'b0;
            o_iter     <= '0;
        end else begin
            state      <= nxt;
            o_busy     <= nxt != S_IDLE;
            o_llr_load <= nxt == S_LOAD;
            o_c2v_clr  <= nxt == S_LOAD || (nxt == S_VN && (state == S_LOAD || o_c2v_clr));
            o_vn_en    <= nxt == S_VN;
            o_cn_en    <= nxt == S_CN;
            o_valid    <= nxt == S_DONE;
            o_success  <= nxt == S_DONE && (state == S_DONE ? o_success : i_syn_ok);
            if (state == S_IDLE && i_start)
                lim <= i_max_iter == '0 ? MAX_ITER_W'(1) : i_max_iter;
            if (state == S_LOAD)
                o_iter <= '0;
            else if (state == S_CHECK && !(&o_iter))
                o_iter <= o_iter + 1'b1;
        end
    end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb_ldpc_iter_ctrl: directed cycle-by-cycle checks of the LDPC iteration controller
module tb_ldpc_iter_ctrl;

    localparam int W = 5;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [W-1:0] i_max_iter = '0;
    logic         i_syn_ok = 1'b0;
    logic         i_out_ready = 1'b0;
    logic         o_busy, o_llr_load, o_c2v_clr, o_vn_en, o_cn_en, o_valid, o_success;
    logic [W-1:0] o_iter;
    logic [6:0]   outs;

    int checks = 0;
    int errors = 0;

    // {busy, llr_load, c2v_clr, vn_en, cn_en, valid, success}
    localparam logic [6:0] IDLE_O = 7'b0000000;
    localparam logic [6:0] LOAD_O = 7'b1110000;
    localparam logic [6:0] VN1_O  = 7'b1011000;
    localparam logic [6:0] VN_O   = 7'b1001000;
    localparam logic [6:0] CN_O   = 7'b1000100;
    localparam logic [6:0] CHK_O  = 7'b1000000;
    localparam logic [6:0] DONE_S = 7'b1000011;
    localparam logic [6:0] DONE_F = 7'b1000010;

    ldpc_iter_ctrl #(.MAX_ITER_W(W), .VN_LAT(1), .CN_LAT(2)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_max_iter  (i_max_iter),
        .i_syn_ok    (i_syn_ok),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy),
        .o_llr_load  (o_llr_load),
        .o_c2v_clr   (o_c2v_clr),
        .o_vn_en     (o_vn_en),
        .o_cn_en     (o_cn_en),
        .o_valid     (o_valid),
        .o_success   (o_success),
        .o_iter      (o_iter)
    );

    assign outs = {o_busy, o_llr_load, o_c2v_clr, o_vn_en, o_cn_en, o_valid, o_success};

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [6:0] exp);
        tick();
        chk(tag, {25'd0, outs}, {25'd0, exp});
    endtask

    task automatic iter_body(input string tag, input bit first);
        step({tag, "_vn"}, first ? VN1_O : VN_O);
        step({tag, "_cn0"}, CN_O);
        step({tag, "_cn1"}, CN_O);
        step({tag, "_chk"}, CHK_O);
    endtask

    task automatic accept(input string tag);
        i_out_ready = 1'b1;
        step({tag, "_accept"}, IDLE_O);
        i_out_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_outs", {25'd0, outs}, 32'd0);
        chk("rst_iter", {27'd0, o_iter}, 32'd0);
        i_rst_n = 1'b1;

        // early success on the first check
        i_max_iter = 5'd5;
        i_syn_ok   = 1'b1;
        i_start    = 1'b1;
        step("s1_load", LOAD_O);
        i_start = 1'b0;
        iter_body("s1", 1'b1);
        step("s1_done", DONE_S);
        chk("s1_iter", {27'd0, o_iter}, 32'd1);
        accept("s1");

        // limit reached without success; start pulses while busy are ignored
        i_max_iter = 5'd3;
        i_syn_ok   = 1'b0;
        i_start    = 1'b1;
        step("s2_load", LOAD_O);
        i_start = 1'b0;
        step("s2_vn", VN1_O);
        i_start = 1'b1;
        step("s2_cn0", CN_O);
        i_start = 1'b0;
        step("s2_cn1", CN_O);
        step("s2_chk", CHK_O);
        iter_body("s2_i2", 1'b0);
        iter_body("s2_i3", 1'b0);
        step("s2_done", DONE_F);
        chk("s2_iter", {27'd0, o_iter}, 32'd3);
        for (int k = 0; k < 7; k++) begin
            i_start = k[0];
            step("s2_hold", DONE_F);
            chk("s2_hold_iter", {27'd0, o_iter}, 32'd3);
        end
        i_start = 1'b1;
        accept("s2");
        i_start = 1'b0;
        step("s2_idle", IDLE_O);

        // zero limit behaves as one
        i_max_iter = 5'd0;
        i_start    = 1'b1;
        step("s3_load", LOAD_O);
        i_start = 1'b0;
        iter_body("s3", 1'b1);
        step("s3_done", DONE_F);
        chk("s3_iter", {27'd0, o_iter}, 32'd1);
        accept("s3");

        // syndrome-ok outside CHECK is ignored
        i_max_iter = 5'd2;
        i_syn_ok   = 1'b1;
        i_start    = 1'b1;
        step("s4_load", LOAD_O);
        i_start = 1'b0;
        step("s4_vn", VN1_O);
        step("s4_cn0", CN_O);
        step("s4_cn1", CN_O);
        step("s4_chk", CHK_O);
        i_syn_ok = 1'b0;
        step("s4_vn2", VN_O);
        i_syn_ok = 1'b1;
        step("s4_cn2a", CN_O);
        step("s4_cn2b", CN_O);
        step("s4_chk2", CHK_O);
        step("s4_done", DONE_S);
        chk("s4_iter", {27'd0, o_iter}, 32'd2);
        accept("s4");

        // reset during CN of the second iteration aborts the frame
        i_max_iter = 5'd5;
        i_syn_ok   = 1'b0;
        i_start    = 1'b1;
        step("s5_load", LOAD_O);
        i_start = 1'b0;
        iter_body("s5", 1'b1);
        step("s5_vn2", VN_O);
        step("s5_cn2", CN_O);
        i_rst_n = 1'b0;
        step("s5_rst", IDLE_O);
        chk("s5_rst_iter", {27'd0, o_iter}, 32'd0);
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++)
            step("s5_quiet", IDLE_O);
        i_syn_ok = 1'b1;
        i_start  = 1'b1;
        step("s5_reload", LOAD_O);
        i_start = 1'b0;
        iter_body("s5b", 1'b1);
        step("s5_done", DONE_S);
        chk("s5_iter", {27'd0, o_iter}, 32'd1);
        accept("s5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
